// File: rtl/calc1_arb_pkg.sv
// Shared calc1 arbiter definitions: command/response codes, FSM state types, command check.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc1_arb_pkg;

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        P_IDLE,
        P_OPND,
        P_PEND,
        P_ISSUED
    } port_state_e;

    typedef enum logic {
        D_IDLE,
        D_BUSY
    } disp_state_e;

    // Caller zero-extends its command so any CMD_W works here.
    function automatic logic is_valid_cmd(input logic [31:0] cmd);
        return (cmd == 32'(CMD_ADD)) || (cmd == 32'(CMD_SUB)) ||
               (cmd == 32'(CMD_SHL)) || (cmd == 32'(CMD_SHR));
    endfunction

endpackage

// File: rtl/calc1_port_capture.sv
// One calc1 requester port: captures cmd/op1 then op2, holds the request until granted and completed.
// Latency: request pending one edge after op2; invalid commands flag an error one edge after op2.
// Backpressure: none; a command arriving while the port is busy is dropped.
module calc1_port_capture
    import calc1_arb_pkg::*;
#(
    parameter int CMD_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              c_clk,
    input  logic              reset_n,
    input  logic [CMD_W-1:0]  cmd_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              grant,
    input  logic              cpl,
    output logic              pend,
    output logic              byp_err,
    output logic [CMD_W-1:0]  cmd,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2
);

    port_state_e state_q, state_d;
    logic        cmd_ok;

    assign cmd_ok = is_valid_cmd(32'(cmd));
    assign pend   = (state_q == P_PEND);

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= P_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd     <= '0;
            op1     <= '0;
            op2     <= '0;
            byp_err <= 1'b0;
        end else begin
            // Invalid commands never reach the dispatcher; this one-edge flag becomes the error response.
            byp_err <= (state_q == P_OPND) && !cmd_ok;
            if (state_q == P_IDLE && cmd_in != '0) begin
                cmd <= cmd_in;
                op1 <= data_in;
            end
            if (state_q == P_OPND) begin
                op2 <= data_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            P_IDLE:   if (cmd_in != '0) state_d = P_OPND;
            P_OPND:   state_d = cmd_ok ? P_PEND : P_IDLE;
            P_PEND:   if (grant) state_d = P_ISSUED;
            P_ISSUED: if (cpl) state_d = P_IDLE;
            default:  state_d = P_IDLE;
        endcase
    end

endmodule

// File: rtl/calc1_port_arbiter.sv
// Shares one calc1 ALU between four ports: round-robin grant, single op in flight, per-port responses.
// Latency: issue one edge after op2; response one edge after alu_done (or after ALU_TIMEOUT edges).
// Backpressure: ports wait in PEND until granted; busy ports drop new commands silently.
module calc1_port_arbiter
    import calc1_arb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int CMD_W       = 4,
    parameter int RESP_W      = 2,
    parameter int ALU_TIMEOUT = 16
) (
    input  logic              c_clk,
    input  logic              reset_n,
    input  logic [CMD_W-1:0]  req1_cmd_in,
    input  logic [DATA_W-1:0] req1_data_in,
    input  logic [CMD_W-1:0]  req2_cmd_in,
    input  logic [DATA_W-1:0] req2_data_in,
    input  logic [CMD_W-1:0]  req3_cmd_in,
    input  logic [DATA_W-1:0] req3_data_in,
    input  logic [CMD_W-1:0]  req4_cmd_in,
    input  logic [DATA_W-1:0] req4_data_in,
    output logic [RESP_W-1:0] out_resp1,
    output logic [DATA_W-1:0] out_data1,
    output logic [RESP_W-1:0] out_resp2,
    output logic [DATA_W-1:0] out_data2,
    output logic [RESP_W-1:0] out_resp3,
    output logic [DATA_W-1:0] out_data3,
    output logic [RESP_W-1:0] out_resp4,
    output logic [DATA_W-1:0] out_data4,
    output logic              alu_valid,
    output logic [CMD_W-1:0]  alu_cmd,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [RESP_W-1:0] alu_resp
);

    localparam int TW = $clog2(ALU_TIMEOUT);

    logic [CMD_W-1:0]  cmd_in  [4];
    logic [DATA_W-1:0] data_in [4];
    logic [CMD_W-1:0]  p_cmd   [4];
    logic [DATA_W-1:0] p_op1   [4];
    logic [DATA_W-1:0] p_op2   [4];
    logic [RESP_W-1:0] resp_q  [4];
    logic [DATA_W-1:0] data_q  [4];
    logic [3:0]        pend, byp_err, grant, cpl;

    disp_state_e       dstate_q, dstate_d;
    logic [1:0]        rr_ptr, owner, win_idx, cand;
    logic              win_vld, alu_hit, alu_tmo, issue;
    logic [TW-1:0]     tcnt;

    assign cmd_in  = '{req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in};
    assign data_in = '{req1_data_in, req2_data_in, req3_data_in, req4_data_in};

    for (genvar g = 0; g < 4; g++) begin : g_port
        calc1_port_capture #(.CMD_W(CMD_W), .DATA_W(DATA_W)) u_cap (
            .c_clk   (c_clk),
            .reset_n (reset_n),
            .cmd_in  (cmd_in[g]),
            .data_in (data_in[g]),
            .grant   (grant[g]),
            .cpl     (cpl[g]),
            .pend    (pend[g]),
            .byp_err (byp_err[g]),
            .cmd     (p_cmd[g]),
            .op1     (p_op1[g]),
            .op2     (p_op2[g])
        );
    end

    // Scan starts just after the last winner; i == 4 wraps back to the last winner itself.
    always_comb begin
        win_vld = 1'b0;
        win_idx = rr_ptr;
        cand    = rr_ptr;
        for (int i = 1; i <= 4; i++) begin
            cand = rr_ptr + 2'(i);
            if (!win_vld && pend[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign alu_hit = (dstate_q == D_BUSY) && alu_done;
    assign alu_tmo = (dstate_q == D_BUSY) && !alu_done && (tcnt == TW'(ALU_TIMEOUT - 1));
    // A completing op frees the ALU on the same edge, so the next grant can go out back-to-back.
    assign issue   = win_vld && ((dstate_q == D_IDLE) || alu_hit);
    assign grant   = issue ? (4'b0001 << win_idx) : 4'b0000;
    assign cpl     = (alu_hit || alu_tmo) ? (4'b0001 << owner) : 4'b0000;

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            dstate_q <= D_IDLE;
        end else begin
            dstate_q <= dstate_d;
        end
    end

    always_comb begin
        dstate_d = dstate_q;
        case (dstate_q)
            D_IDLE:  if (issue) dstate_d = D_BUSY;
            D_BUSY:  if (alu_hit || alu_tmo) dstate_d = issue ? D_BUSY : D_IDLE;
            default: dstate_d = D_IDLE;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_valid <= 1'b0;
            alu_cmd   <= '0;
            alu_op1   <= '0;
            alu_op2   <= '0;
            rr_ptr    <= 2'd3;
            owner     <= 2'd0;
            tcnt      <= '0;
        end else begin
            alu_valid <= issue;
            if (issue) begin
                alu_cmd <= p_cmd[win_idx];
                alu_op1 <= p_op1[win_idx];
                alu_op2 <= p_op2[win_idx];
                rr_ptr  <= win_idx;
                owner   <= win_idx;
                tcnt    <= '0;
            end else if (dstate_q == D_BUSY) begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 4; p++) begin
                resp_q[p] <= '0;
                data_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                resp_q[p] <= RESP_W'(RESP_NONE);
                data_q[p] <= '0;
                if (byp_err[p]) begin
                    resp_q[p] <= RESP_W'(RESP_ERR);
                end else if (cpl[p]) begin
                    resp_q[p] <= alu_hit ? alu_resp : RESP_W'(RESP_ERR);
                    if (alu_hit && alu_resp == RESP_W'(RESP_OK)) begin
                        data_q[p] <= alu_result;
                    end
                end
            end
        end
    end

    assign out_resp1 = resp_q[0];
    assign out_resp2 = resp_q[1];
    assign out_resp3 = resp_q[2];
    assign out_resp4 = resp_q[3];
    assign out_data1 = data_q[0];
    assign out_data2 = data_q[1];
    assign out_data3 = data_q[2];
    assign out_data4 = data_q[3];

endmodule

// File: tb/tb_calc1_port_arbiter.sv
// Directed bench for calc1_port_arbiter with a behavioural ALU of programmable latency.
// Latency/backpressure: n/a (testbench).
// Expected values are hand-computed constants in the stimulus sequence.
module tb_calc1_port_arbiter;

    logic        c_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  cmd_a [1:4];
    logic [31:0] dat_a [1:4];
    logic [1:0]  out_resp1, out_resp2, out_resp3, out_resp4;
    logic [31:0] out_data1, out_data2, out_data3, out_data4;
    logic [1:0]  resp_a [1:4];
    logic [31:0] odat_a [1:4];
    logic        alu_valid;
    logic [3:0]  alu_cmd;
    logic [31:0] alu_op1, alu_op2;
    logic        alu_done = 1'b0;
    logic [31:0] alu_result = '0;
    logic [1:0]  alu_resp = '0;

    int          vectors = 0;
    int          miscompares = 0;
    int          alu_k = 1;
    bit          alu_err = 1'b0;
    int          alu_cnt = 0;
    logic [3:0]  la_cmd;
    logic [31:0] la_a, la_b;
    int          resp_cnt [1:4];
    logic [31:0] last_data [1:4];
    logic [31:0] issue_op1 [$];
    logic [3:0]  bad_cmds [3];
    int          base_cnt, base_iss;

    always #5 c_clk = ~c_clk;

    calc1_port_arbiter dut (
        .c_clk        (c_clk),
        .reset_n      (reset_n),
        .req1_cmd_in  (cmd_a[1]),
        .req1_data_in (dat_a[1]),
        .req2_cmd_in  (cmd_a[2]),
        .req2_data_in (dat_a[2]),
        .req3_cmd_in  (cmd_a[3]),
        .req3_data_in (dat_a[3]),
        .req4_cmd_in  (cmd_a[4]),
        .req4_data_in (dat_a[4]),
        .out_resp1    (out_resp1),
        .out_data1    (out_data1),
        .out_resp2    (out_resp2),
        .out_data2    (out_data2),
        .out_resp3    (out_resp3),
        .out_data3    (out_data3),
        .out_resp4    (out_resp4),
        .out_data4    (out_data4),
        .alu_valid    (alu_valid),
        .alu_cmd      (alu_cmd),
        .alu_op1      (alu_op1),
        .alu_op2      (alu_op2),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .alu_resp     (alu_resp)
    );

    assign resp_a[1] = out_resp1;
    assign resp_a[2] = out_resp2;
    assign resp_a[3] = out_resp3;
    assign resp_a[4] = out_resp4;
    assign odat_a[1] = out_data1;
    assign odat_a[2] = out_data2;
    assign odat_a[3] = out_data3;
    assign odat_a[4] = out_data4;

    // Behavioural ALU: done strobe alu_k cycles after the cycle alu_valid is seen.
    always @(negedge c_clk) begin
        alu_done   = 1'b0;
        alu_result = '0;
        alu_resp   = 2'd0;
        if (alu_cnt > 0) begin
            alu_cnt = alu_cnt - 1;
            if (alu_cnt == 0) begin
                alu_done = 1'b1;
                if (alu_err) begin
                    alu_resp   = 2'd2;
                    alu_result = 32'hDEAD_BEEF;
                end else begin
                    alu_resp = 2'd1;
                    case (la_cmd)
                        4'd1:    alu_result = la_a + la_b;
                        4'd2:    alu_result = la_a - la_b;
                        4'd5:    alu_result = la_a << la_b[4:0];
                        default: alu_result = la_a >> la_b[4:0];
                    endcase
                end
            end
        end
        if (alu_valid) begin
            alu_cnt = alu_k;
            la_cmd  = alu_cmd;
            la_a    = alu_op1;
            la_b    = alu_op2;
        end
    end

    always @(negedge c_clk) begin
        if (alu_valid) issue_op1.push_back(alu_op1);
        for (int p = 1; p <= 4; p++) begin
            if (resp_a[p] != 2'd0) begin
                resp_cnt[p]  = resp_cnt[p] + 1;
                last_data[p] = odat_a[p];
            end
        end
    end

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        cmd_a[p] = c;
        dat_a[p] = a;
        tick();
        cmd_a[p] = 4'd0;
        dat_a[p] = b;
        tick();
        dat_a[p] = '0;
    endtask

    initial begin
        for (int p = 1; p <= 4; p++) begin
            cmd_a[p]     = 4'd0;
            dat_a[p]     = '0;
            resp_cnt[p]  = 0;
            last_data[p] = '0;
        end
        bad_cmds = '{4'd3, 4'd4, 4'd9};

        // Reset state
        #2;
        chk("reset alu_valid", alu_valid, 0);
        chk("reset alu_op1", alu_op1, 0);
        for (int p = 1; p <= 4; p++) begin
            chk($sformatf("reset resp%0d", p), resp_a[p], 0);
            chk($sformatf("reset data%0d", p), odat_a[p], 0);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // All four ports request together; order follows the post-reset pointer
        for (int p = 1; p <= 4; p++) begin
            cmd_a[p] = 4'd1;
            dat_a[p] = 32'h10 * p;
        end
        tick();
        for (int p = 1; p <= 4; p++) begin
            cmd_a[p] = 4'd0;
            dat_a[p] = p;
        end
        tick();
        for (int p = 1; p <= 4; p++) dat_a[p] = '0;
        tick();
        chk("rr first issue valid", alu_valid, 1);
        chk("rr first issue op1", alu_op1, 32'h10);
        tick();
        chk("rr strobe one cycle", alu_valid, 0);
        tick();
        chk("rr back-to-back valid", alu_valid, 1);
        chk("rr back-to-back op1", alu_op1, 32'h20);
        chk("rr port1 resp", out_resp1, 1);
        chk("rr port1 data", out_data1, 32'h11);
        repeat (8) tick();
        chk("rr issue count", issue_op1.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr order %0d", i), issue_op1[i], 32'h10 * (i + 1));
            chk($sformatf("rr resp count p%0d", i + 1), resp_cnt[i + 1], 1);
            chk($sformatf("rr data p%0d", i + 1), last_data[i + 1], 32'h11 * (i + 1));
        end

        // Ports 3 and 1 together after pointer rests on port 4
        cmd_a[3] = 4'd1; dat_a[3] = 32'h103;
        cmd_a[1] = 4'd1; dat_a[1] = 32'h101;
        tick();
        cmd_a[3] = 4'd0; dat_a[3] = '0;
        cmd_a[1] = 4'd0; dat_a[1] = '0;
        tick();
        repeat (8) tick();
        chk("rr2 issue count", issue_op1.size(), 6);
        chk("rr2 first port1", issue_op1[4], 32'h101);
        chk("rr2 second port3", issue_op1[5], 32'h103);
        chk("rr2 port1 count", resp_cnt[1], 2);
        chk("rr2 port3 count", resp_cnt[3], 2);
        chk("rr2 port2 count", resp_cnt[2], 1);
        chk("rr2 port4 count", resp_cnt[4], 1);
        chk("rr2 port3 data", last_data[3], 32'h103);

        // Single add, ALU latency 1, minimum response latency
        send(1, 4'd1, 32'h1, 32'h1FFF_FFFF);
        tick();
        chk("add alu_valid", alu_valid, 1);
        chk("add alu_cmd", alu_cmd, 1);
        chk("add alu_op1", alu_op1, 32'h1);
        chk("add alu_op2", alu_op2, 32'h1FFF_FFFF);
        tick();
        chk("add resp early", out_resp1, 0);
        tick();
        chk("add resp1", out_resp1, 1);
        chk("add data1", out_data1, 32'h2000_0000);
        chk("add resp2 idle", out_resp2, 0);
        chk("add resp3 idle", out_resp3, 0);
        chk("add resp4 idle", out_resp4, 0);
        tick();
        chk("add resp1 one cycle", out_resp1, 0);
        chk("add data1 cleared", out_data1, 0);

        // Invalid commands bypass the ALU
        base_iss = issue_op1.size();
        for (int i = 0; i < 3; i++) begin
            send(2, bad_cmds[i], 32'hAA, 32'hBB);
            chk($sformatf("bad%0d resp before", i), out_resp2, 0);
            tick();
            chk($sformatf("bad%0d resp2", i), out_resp2, 2);
            chk($sformatf("bad%0d data2", i), out_data2, 0);
            tick();
            chk($sformatf("bad%0d resp2 one cycle", i), out_resp2, 0);
        end
        chk("bad no issue", issue_op1.size(), base_iss);

        // ALU error status, plus a command dropped while the port is ISSUED
        alu_k    = 3;
        alu_err  = 1'b1;
        base_cnt = resp_cnt[1];
        base_iss = issue_op1.size();
        send(1, 4'd2, 32'h1, 32'hF);
        tick();
        cmd_a[1] = 4'd1; dat_a[1] = 32'h55;
        tick();
        cmd_a[1] = 4'd0; dat_a[1] = 32'h66;
        tick();
        dat_a[1] = '0;
        tick();
        chk("err resp early", out_resp1, 0);
        tick();
        chk("err resp1", out_resp1, 2);
        chk("err data1 masked", out_data1, 0);
        repeat (10) tick();
        chk("err single response", resp_cnt[1], base_cnt + 1);
        chk("err single issue", issue_op1.size(), base_iss + 1);
        alu_err = 1'b0;

        // Timeout: ALU answers only after 20 cycles
        alu_k    = 20;
        base_cnt = resp_cnt[3];
        send(3, 4'd1, 32'h7, 32'h8);
        tick();
        chk("tmo issue", alu_valid, 1);
        repeat (15) tick();
        chk("tmo resp before limit", out_resp3, 0);
        tick();
        chk("tmo resp3", out_resp3, 2);
        chk("tmo data3", out_data3, 0);
        repeat (8) tick();
        chk("tmo late done ignored", resp_cnt[3], base_cnt + 1);
        alu_k = 1;
        send(3, 4'd1, 32'h3, 32'h4);
        tick();
        tick();
        tick();
        chk("post-tmo resp3", out_resp3, 1);
        chk("post-tmo data3", out_data3, 32'h7);

        // Asynchronous reset while port 4 is in flight
        alu_k    = 5;
        base_cnt = resp_cnt[4];
        send(4, 4'd1, 32'h1, 32'h2);
        tick();
        chk("rst pre issue", alu_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("rst alu_valid", alu_valid, 0);
        chk("rst alu_op1", alu_op1, 0);
        chk("rst alu_cmd", alu_cmd, 0);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("rst no port4 response", resp_cnt[4], base_cnt);
        alu_k = 1;
        send(1, 4'd5, 32'h1, 32'h1);
        tick();
        tick();
        tick();
        chk("shl resp1", out_resp1, 1);
        chk("shl data1", out_data1, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
